// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag indices and state types for the sequential ALU.
package alu_pkg;

   localparam int unsigned FLAG_W = 5;
   localparam int unsigned FLAG_C = 4;
   localparam int unsigned FLAG_L = 3;
   localparam int unsigned FLAG_F = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_N = 0;

   // op_hi values
   localparam logic [3:0] OP_HI_RTYPE = 4'b0000;
   localparam logic [3:0] OP_HI_ANDI  = 4'b0001;
   localparam logic [3:0] OP_HI_ORI   = 4'b0010;
   localparam logic [3:0] OP_HI_XORI  = 4'b0011;
   localparam logic [3:0] OP_HI_ADDI  = 4'b0101;
   localparam logic [3:0] OP_HI_SHIFT = 4'b1000;
   localparam logic [3:0] OP_HI_SUBI  = 4'b1001;
   localparam logic [3:0] OP_HI_CMPI  = 4'b1011;
   localparam logic [3:0] OP_HI_MOVI  = 4'b1101;
   localparam logic [3:0] OP_HI_LUI   = 4'b1111;

   // op_ext values (register forms and shift group)
   localparam logic [3:0] OP_EXT_AND  = 4'b0001;
   localparam logic [3:0] OP_EXT_OR   = 4'b0010;
   localparam logic [3:0] OP_EXT_XOR  = 4'b0011;
   localparam logic [3:0] OP_EXT_LSH  = 4'b0100;
   localparam logic [3:0] OP_EXT_ADD  = 4'b0101;
   localparam logic [3:0] OP_EXT_ASHU = 4'b0110;
   localparam logic [3:0] OP_EXT_SUB  = 4'b1001;
   localparam logic [3:0] OP_EXT_CMP  = 4'b1011;
   localparam logic [3:0] OP_EXT_MOV  = 4'b1101;
   localparam logic [3:0] OP_EXT_MUL  = 4'b1110;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef enum logic [1:0] {IT_SHL, IT_SHR, IT_SAR, IT_MUL} iter_mode_t;

   typedef enum logic [3:0] {
      K_AND, K_OR, K_XOR, K_ADD, K_SUB, K_CMP, K_MOV, K_MUL, K_LUI, K_SHIFT, K_ILL
   } kind_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative engine: one shift step or one shift-add MUL step per cycle.
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             step,
   input  logic [1:0]       mode,
   input  logic [AMT_W-1:0] count,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done_c,
   output logic [WIDTH-1:0] res_c
);

   logic [AMT_W-1:0] cnt;
   iter_mode_t       mode_q;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;

   // Value acc takes after the current step; presented so the final step lands in the output register directly
   always_comb begin
      res_c = acc;
      case (mode_q)
         IT_SHL:  res_c = acc << 1;
         IT_SHR:  res_c = acc >> 1;
         IT_SAR:  res_c = {acc[WIDTH-1], acc[WIDTH-1:1]};
         default: res_c = acc + (mplier[0] ? mcand : '0);
      endcase
   end

   assign done_c = step && (cnt == AMT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         mode_q <= IT_SHL;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         cnt    <= count;
         mode_q <= iter_mode_t'(mode);
         acc    <= (iter_mode_t'(mode) == IT_MUL) ? '0 : a;
         mcand  <= a;
         mplier <= b;
      end else if (step && (cnt != '0)) begin
         cnt    <= cnt - AMT_W'(1);
         acc    <= res_c;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle CR16-style ALU with registered PSR and valid/ready on both sides.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned IMM_W = 8,
   parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        opcode,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic              wb_en,
   output logic              illegal,
   output logic [FLAG_W-1:0] flags
);

   state_t             state, state_n;
   kind_t              kind;
   logic [3:0]         op_hi, op_ext;
   logic [WIDTH-1:0]   bv, sext, zext;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   sc_res;
   logic               sc_wb, sc_ill;
   logic [FLAG_W-1:0]  flags_n;
   logic [AMT_W-1:0]   amt, mag, it_count;
   iter_mode_t         it_mode;
   logic               is_iter, accept, start, ld_sc, ld_it, it_done_c;
   logic [WIDTH-1:0]   it_res_c;

   assign op_hi  = opcode[7:4];
   assign op_ext = opcode[3:0];
   assign sext   = {{(WIDTH-IMM_W){b[IMM_W-1]}}, b[IMM_W-1:0]};
   assign zext   = WIDTH'(b[IMM_W-1:0]);

   // Decode into an operation kind and the effective second operand
   always_comb begin
      kind = K_ILL;
      bv   = b;
      case (op_hi)
         OP_HI_RTYPE: begin
            case (op_ext)
               OP_EXT_AND: kind = K_AND;
               OP_EXT_OR:  kind = K_OR;
               OP_EXT_XOR: kind = K_XOR;
               OP_EXT_ADD: kind = K_ADD;
               OP_EXT_SUB: kind = K_SUB;
               OP_EXT_CMP: kind = K_CMP;
               OP_EXT_MOV: kind = K_MOV;
               OP_EXT_MUL: kind = K_MUL;
               default:    kind = K_ILL;
            endcase
         end
         OP_HI_ANDI:  begin kind = K_AND; bv = zext; end
         OP_HI_ORI:   begin kind = K_OR;  bv = zext; end
         OP_HI_XORI:  begin kind = K_XOR; bv = zext; end
         OP_HI_MOVI:  begin kind = K_MOV; bv = zext; end
         OP_HI_ADDI:  begin kind = K_ADD; bv = sext; end
         OP_HI_SUBI:  begin kind = K_SUB; bv = sext; end
         OP_HI_CMPI:  begin kind = K_CMP; bv = sext; end
         OP_HI_LUI:   kind = K_LUI;
         OP_HI_SHIFT: begin
            if (op_ext == OP_EXT_LSH || op_ext == OP_EXT_ASHU) kind = K_SHIFT;
         end
         default:     kind = K_ILL;
      endcase
   end

   assign sum  = {1'b0, a} + {1'b0, bv};
   assign diff = a - bv;

   // Single-cycle results and flag updates; untouched flags carry over
   always_comb begin
      sc_res  = '0;
      sc_wb   = 1'b1;
      sc_ill  = 1'b0;
      flags_n = flags;
      case (kind)
         K_AND: sc_res = a & bv;
         K_OR:  sc_res = a | bv;
         K_XOR: sc_res = a ^ bv;
         K_MOV: sc_res = bv;
         K_LUI: sc_res = {b[IMM_W-1:0], {(WIDTH-IMM_W){1'b0}}};
         K_ADD: begin
            sc_res          = sum[WIDTH-1:0];
            flags_n[FLAG_C] = sum[WIDTH];
            flags_n[FLAG_F] = (a[WIDTH-1] == bv[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         K_SUB: begin
            sc_res          = diff;
            flags_n[FLAG_C] = a < bv;
            flags_n[FLAG_F] = (a[WIDTH-1] != bv[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         K_CMP: begin
            sc_wb           = 1'b0;
            flags_n[FLAG_Z] = a == bv;
            flags_n[FLAG_L] = a < bv;
            flags_n[FLAG_N] = $signed(a) < $signed(bv);
         end
         K_SHIFT: sc_res = a;
         K_MUL:   sc_res = '0;
         default: begin
            sc_wb  = 1'b0;
            sc_ill = 1'b1;
         end
      endcase
   end

   // Iterative setup: signed shift amount magnitude selects the step count
   assign amt = b[AMT_W-1:0];
   assign mag = amt[AMT_W-1] ? (~amt + AMT_W'(1)) : amt;

   always_comb begin
      it_mode  = IT_SHL;
      it_count = mag;
      if (kind == K_MUL) begin
         it_mode  = IT_MUL;
         it_count = AMT_W'(WIDTH);
      end else if (amt[AMT_W-1]) begin
         it_mode  = (op_ext == OP_EXT_ASHU) ? IT_SAR : IT_SHR;
      end
   end

   assign is_iter = (kind == K_MUL) || ((kind == K_SHIFT) && (mag != '0));

   always_comb begin
      state_n  = state;
      start    = 1'b0;
      ld_sc    = 1'b0;
      ld_it    = 1'b0;
      in_ready = (state == IDLE) || ((state == DONE) && out_ready);
      accept   = in_valid && in_ready;
      case (state)
         IDLE, DONE: begin
            if ((state == DONE) && out_ready) state_n = IDLE;
            if (accept) begin
               if (is_iter) begin
                  state_n = BUSY;
                  start   = 1'b1;
               end else begin
                  state_n = DONE;
                  ld_sc   = 1'b1;
               end
            end
         end
         BUSY: begin
            if (it_done_c) begin
               state_n = DONE;
               ld_it   = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result  <= '0;
         wb_en   <= 1'b0;
         illegal <= 1'b0;
         flags   <= '0;
      end else if (ld_sc) begin
         result  <= sc_res;
         wb_en   <= sc_wb;
         illegal <= sc_ill;
         flags   <= flags_n;
      end else if (ld_it) begin
         result  <= it_res_c;
         wb_en   <= 1'b1;
         illegal <= 1'b0;
      end
   end

   alu_iter_unit #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .step   (state == BUSY),
      .mode   (it_mode),
      .count  (it_count),
      .a      (a),
      .b      (b),
      .done_c (it_done_c),
      .res_c  (it_res_c)
   );

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized bench for alu_seq against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  opcode = '0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result;
   logic        wb_en;
   logic        illegal;
   logic [4:0]  flags;

   int          checks = 0;
   int          errors = 0;
   logic [4:0]  mflags = '0;
   logic [15:0] obs_res;
   logic [4:0]  obs_flags;
   int          obs_lat;

   logic [7:0]  all_ops [20] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h09, 8'h0B, 8'h0D, 8'h0E,
                                8'h1C, 8'h27, 8'h33, 8'h5A, 8'h96, 8'hB1, 8'hD5, 8'hF3,
                                8'h84, 8'h86, 8'h0F, 8'h40};
   logic [7:0]  sc_ops [10]  = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h09, 8'h0B, 8'h0D,
                                8'h5F, 8'h9E, 8'hB2};

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(16), .IMM_W(8), .AMT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .wb_en     (wb_en),
      .illegal   (illegal),
      .flags     (flags)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: behaviour straight from the opcode table with plain integer arithmetic
   function automatic void model(input logic [7:0] op, input logic [15:0] av, input logic [15:0] bv,
                                 input logic [4:0] fin, output logic [15:0] r, output logic w,
                                 output logic il, output logic [4:0] fo, output int lat);
      int unsigned ua, ub;
      int          sa, sb, ss, sh, m, code;
      logic [3:0]  hi, ext;
      logic [15:0] bb;
      hi = op[7:4]; ext = op[3:0];
      r = '0; w = 1'b1; il = 1'b0; fo = fin; lat = 1; bb = bv;
      if (hi == 4'h0) begin
         code = int'(ext);
         if (!(ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hE})) code = 0;
      end else if (hi == 4'h8) begin
         code = (ext == 4'h4) ? 16 : (ext == 4'h6) ? 17 : 0;
      end else begin
         code = int'(hi);
         if (!(hi inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF})) code = 0;
         if (hi inside {4'h5, 4'h9, 4'hB}) bb = {{8{bv[7]}}, bv[7:0]};
         else                              bb = {8'h00, bv[7:0]};
      end
      ua = int'(av); ub = int'(bb);
      sa = int'($signed(av)); sb = int'($signed(bb));
      case (code)
         1:  r = 16'(ua & ub);
         2:  r = 16'(ua | ub);
         3:  r = 16'(ua ^ ub);
         5: begin
            r = 16'(ua + ub); ss = sa + sb;
            fo[4] = (ua + ub) > 65535;
            fo[2] = (ss > 32767) || (ss < -32768);
         end
         9: begin
            r = 16'(ua - ub); ss = sa - sb;
            fo[4] = ua < ub;
            fo[2] = (ss > 32767) || (ss < -32768);
         end
         11: begin
            w = 1'b0;
            fo[1] = ua == ub; fo[3] = ua < ub; fo[0] = sa < sb;
         end
         13: r = 16'(ub);
         14: begin r = 16'(ua * ub); lat = 17; end
         15: r = 16'({bv[7:0], 8'h00});
         16, 17: begin
            sh = int'($signed(bv[4:0]));
            if (sh > 0) begin
               r = 16'(ua << sh); lat = 1 + sh;
            end else if (sh < 0) begin
               m = -sh; lat = 1 + m;
               if (code == 16) r = 16'(ua >> m);
               else            r = 16'(sa >>> m);
            end else begin
               r = av;
            end
         end
         default: begin w = 1'b0; il = 1'b1; end
      endcase
   endfunction

   // Issue one op from IDLE with out_ready high; starts and ends just after a falling edge
   task automatic do_op(input logic [7:0] op, input logic [15:0] av, input logic [15:0] bv);
      logic [15:0] er;
      logic        ew, eil;
      logic [4:0]  ef;
      int          el, n;
      model(op, av, bv, mflags, er, ew, eil, ef, el);
      mflags = ef;
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; opcode = op; a = av; b = bv; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; opcode = 8'($urandom); a = 16'($urandom); b = 16'($urandom);
      n = 1;
      while (!out_valid && n < 64) begin
         @(negedge clk);
         n++;
      end
      obs_lat = n; obs_res = result; obs_flags = flags;
      chk($sformatf("latency op%02h", op), 32'(n), 32'(el));
      chk($sformatf("result op%02h a%04h b%04h", op, av, bv), 32'(result), 32'(er));
      chk($sformatf("wb_en op%02h", op), 32'(wb_en), 32'(ew));
      chk($sformatf("illegal op%02h", op), 32'(illegal), 32'(eil));
      chk($sformatf("flags op%02h", op), 32'(flags), 32'(ef));
      @(negedge clk);
      chk("out_valid_drop", 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [15:0] er, er2;
      logic        ew, eil;
      logic [4:0]  ef, ef2;
      int          el;
      logic [7:0]  op;
      logic [15:0] av, bv;

      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_wb_en", 32'(wb_en), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(8'h05, 16'h7FFF, 16'h0001);
      chk("add_ovf_res", 32'(obs_res), 32'h8000);
      chk("add_ovf_F", 32'(obs_flags[2]), 32'd1);
      chk("add_ovf_C", 32'(obs_flags[4]), 32'd0);
      chk("add_lat", 32'(obs_lat), 32'd1);

      do_op(8'h90, 16'h0000, 16'h0001);
      chk("subi_res", 32'(obs_res), 32'hFFFF);
      chk("subi_C", 32'(obs_flags[4]), 32'd1);
      do_op(8'hB0, 16'd10, 16'd20);
      chk("cmpi_flags", 32'(obs_flags), 32'b11001);
      chk("cmpi_wb", 32'(wb_en), 32'd0);

      do_op(8'h84, 16'h0001, 16'h000F);
      chk("lsh15_res", 32'(obs_res), 32'h8000);
      chk("lsh15_lat", 32'(obs_lat), 32'd16);
      do_op(8'h86, 16'h8000, 16'hFFFC);
      chk("ashu_m4_res", 32'(obs_res), 32'hF800);
      chk("ashu_m4_lat", 32'(obs_lat), 32'd5);
      do_op(8'h0E, 16'h0123, 16'h0045);
      chk("mul_res", 32'(obs_res), 32'h4E6F);
      chk("mul_lat", 32'(obs_lat), 32'd17);
      do_op(8'hF0, 16'h1234, 16'h00AB);
      chk("lui_res", 32'(obs_res), 32'hAB00);

      // Boundary shifts and illegal opcodes
      do_op(8'h84, 16'hBEEF, 16'h0000);
      do_op(8'h86, 16'h8001, 16'h0010);
      chk("ashu_m16_res", 32'(obs_res), 32'hFFFF);
      do_op(8'h84, 16'hFFFF, 16'h0010);
      chk("lsh_m16_res", 32'(obs_res), 32'h0000);
      do_op(8'h86, 16'h0001, 16'h000F);
      do_op(8'h07, 16'h1111, 16'h2222);
      do_op(8'h85, 16'h1111, 16'h0001);
      do_op(8'h40, 16'h1111, 16'h0001);

      // Stall: result held while out_ready low; a pending op must not be taken early
      model(8'h05, 16'h1234, 16'hF321, mflags, er, ew, eil, ef, el);
      mflags = ef;
      in_valid = 1'b1; opcode = 8'h05; a = 16'h1234; b = 16'hF321; out_ready = 1'b0;
      @(negedge clk);
      opcode = 8'h03; a = 16'hF0F0; b = 16'hFF00;
      model(8'h03, 16'hF0F0, 16'hFF00, mflags, er2, ew, eil, ef2, el);
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_result", 32'(result), 32'(er));
         chk("stall_flags", 32'(flags), 32'(ef));
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      mflags = ef2;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_result", 32'(result), 32'(er2));
      chk("b2b_flags", 32'(flags), 32'(ef2));
      @(negedge clk);
      chk("b2b_drop", 32'(out_valid), 32'd0);

      // Full-rate burst of single-cycle ops
      for (int i = 0; i < 8; i++) begin
         op = sc_ops[$urandom_range(0, 9)]; av = 16'($urandom); bv = 16'($urandom);
         model(op, av, bv, mflags, er, ew, eil, ef, el);
         mflags = ef;
         in_valid = 1'b1; opcode = op; a = av; b = bv;
         @(negedge clk);
         chk("burst_valid", 32'(out_valid), 32'd1);
         chk($sformatf("burst_result op%02h", op), 32'(result), 32'(er));
         chk("burst_flags", 32'(flags), 32'(ef));
         chk("burst_wb_en", 32'(wb_en), 32'(ew));
      end
      in_valid = 1'b0;
      @(negedge clk);

      // Randomized ops through the full opcode space
      for (int i = 0; i < 60; i++) begin
         if (i % 3 == 0) op = 8'($urandom);
         else            op = all_ops[$urandom_range(0, 19)];
         do_op(op, 16'($urandom), 16'($urandom));
      end

      // Reset in the middle of a MUL
      do_op(8'h90, 16'h0000, 16'h0001);
      in_valid = 1'b1; opcode = 8'h0E; a = 16'h00FF; b = 16'h0101; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("mul_busy_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_flags", 32'(flags), 32'd0);
      chk("midrst_result", 32'(result), 32'd0);
      mflags = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_in_ready", 32'(in_ready), 32'd1);
      repeat (20) @(negedge clk);
      chk("postrst_no_valid", 32'(out_valid), 32'd0);
      do_op(8'h05, 16'h8000, 16'h8000);
      chk("postrst_add_res", 32'(obs_res), 32'h0000);
      chk("postrst_add_flags", 32'(obs_flags), 32'b10100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
